// File: rtl/dffes_scan_readback.sv
// Readback serializer: snapshots WIDTH flop Q outputs on start and streams them
// out one bit per accepted beat over a valid/ready serial link.
module dffes_scan_readback #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_adv;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             first_bit;
    logic             next_bit;

    // Output-end bit selection; fill bit shifted in is always 0.
    always_comb begin
        if (MSB_FIRST) begin
            shift_adv = shift_q << 1;
            first_bit = data_in[WIDTH-1];
            next_bit  = shift_adv[WIDTH-1];
        end else begin
            shift_adv = shift_q >> 1;
            first_bit = data_in[0];
            next_bit  = shift_adv[0];
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        busy_d         = busy_q;
        done_d         = done_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d        = data_in;
                    cnt_d          = CW'(WIDTH - 1);
                    busy_d         = 1'b1;
                    serial_valid_d = 1'b1;
                    serial_out_d   = first_bit;
                    state_d        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (serial_valid_q && serial_ready) begin
                    if (cnt_q == '0) begin
                        serial_valid_d = 1'b0;
                        done_d         = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = ST_DONE;
                    end else begin
                        shift_d      = shift_adv;
                        serial_out_d = next_bit;
                        cnt_d        = cnt_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_dffes_scan_readback.sv
// Directed bench for dffes_scan_readback: MSB-first, LSB-first and WIDTH=1 instances.
module tb_dffes_scan_readback;

    logic clk;
    logic clk_run;
    logic R;

    logic        st_m, rdy_m, out_m, vld_m, busy_m, done_m;
    logic [15:0] din_m;
    logic        st_l, rdy_l, out_l, vld_l, busy_l, done_l;
    logic [15:0] din_l;
    logic        st_w, rdy_w, out_w, vld_w, busy_w, done_w;
    logic [0:0]  din_w;

    int n_checks;
    int n_pass;

    dffes_scan_readback #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .R(R), .start(st_m), .data_in(din_m),
        .serial_out(out_m), .serial_valid(vld_m), .serial_ready(rdy_m),
        .busy(busy_m), .done(done_m)
    );

    dffes_scan_readback #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .R(R), .start(st_l), .data_in(din_l),
        .serial_out(out_l), .serial_valid(vld_l), .serial_ready(rdy_l),
        .busy(busy_l), .done(done_l)
    );

    dffes_scan_readback #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .R(R), .start(st_w), .data_in(din_w),
        .serial_out(out_w), .serial_valid(vld_w), .serial_ready(rdy_w),
        .busy(busy_w), .done(done_w)
    );

    // Gateable clock so reset can be shown to act with no edge present.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task test_reset;
        R = 1'b0;
        repeat (3) step;
        R = 1'b1;
        step;
        chk("idle_valid", 32'(vld_m), 32'd0);
        chk("idle_busy", 32'(busy_m), 32'd0);
        din_m = 16'hFFFF; rdy_m = 1'b1; st_m = 1'b1;
        step;
        st_m = 1'b0;
        step; step;
        chk("mid_busy", 32'(busy_m), 32'd1);
        chk("mid_out", 32'(out_m), 32'd1);
        clk_run = 1'b0;
        #20;
        R = 1'b0;
        #1;
        chk("rst_valid", 32'(vld_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        chk("rst_out", 32'(out_m), 32'd0);
        #2;
        R = 1'b1;
        clk_run = 1'b1;
        step;
        chk("post_rst_idle", 32'(vld_m), 32'd0);
    endtask

    task test_basic_msb;
        logic [15:0] stream;
        logic        ok;
        stream = '0; ok = 1'b1;
        din_m = 16'hA5C3; rdy_m = 1'b1; st_m = 1'b1;
        step;
        st_m = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!vld_m || !busy_m || done_m) ok = 1'b0;
            stream = {stream[14:0], out_m};
            step;
        end
        chk("basic_stream", 32'(stream), 32'h0000A5C3);
        chk("basic_flags", 32'(ok), 32'd1);
        chk("basic_done", 32'(done_m), 32'd1);
        chk("basic_busy_low", 32'(busy_m), 32'd0);
        chk("basic_valid_low", 32'(vld_m), 32'd0);
        step;
        chk("basic_done_1cyc", 32'(done_m), 32'd0);
    endtask

    task test_backpressure;
        logic [15:0] stream;
        logic [3:0]  pat;
        logic        hold_ok, prev_stall, prev_bit, rdy;
        int          acc, k;
        stream = '0; pat = 4'b1001; hold_ok = 1'b1; prev_stall = 1'b0; prev_bit = 1'b0;
        acc = 0; k = 0;
        din_m = 16'hA5C3; rdy_m = 1'b0; st_m = 1'b1;
        step;
        st_m = 1'b0;
        while (acc < 16 && k < 200) begin
            if (prev_stall && (!vld_m || out_m !== prev_bit)) hold_ok = 1'b0;
            if (done_m) hold_ok = 1'b0;
            rdy = pat[3 - (k % 4)];
            rdy_m = rdy;
            if (rdy && vld_m) begin
                stream = {stream[14:0], out_m};
                acc++;
            end
            prev_stall = !rdy;
            prev_bit = out_m;
            step;
            k++;
        end
        chk("bp_accepted", 32'(acc), 32'd16);
        chk("bp_hold", 32'(hold_ok), 32'd1);
        chk("bp_stream", 32'(stream), 32'h0000A5C3);
        chk("bp_done", 32'(done_m), 32'd1);
        rdy_m = 1'b1;
        step;
    endtask

    task test_lsb_data_change;
        logic [15:0] stream;
        stream = '0;
        din_l = 16'h0001; rdy_l = 1'b1; st_l = 1'b1;
        step;
        st_l = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stream[i] = out_l;
            step;
            if (i == 0) din_l = 16'hFFFF;
        end
        chk("lsb_stream", 32'(stream), 32'h00000001);
        chk("lsb_done", 32'(done_l), 32'd1);
        step;
    endtask

    task test_ignored_start;
        logic [15:0] stream;
        int          dones;
        stream = '0; dones = 0;
        din_m = 16'h8001; rdy_m = 1'b1; st_m = 1'b1;
        step;
        for (int i = 0; i < 16; i++) begin
            if (done_m) dones++;
            stream = {stream[14:0], out_m};
            step;
        end
        chk("hold_start_stream", 32'(stream), 32'h00008001);
        chk("hold_start_early_done", 32'(dones), 32'd0);
        chk("hold_start_done", 32'(done_m), 32'd1);
        din_m = 16'h1234;
        step;
        chk("hold_start_idle_gap", 32'({vld_m, busy_m, done_m}), 32'd0);
        step;
        chk("hold_start_recapture", 32'({vld_m, busy_m, out_m}), 32'b110);
        st_m = 1'b0;
        stream = '0;
        for (int i = 0; i < 16; i++) begin
            stream = {stream[14:0], out_m};
            step;
        end
        chk("second_stream", 32'(stream), 32'h00001234);
        chk("second_done", 32'(done_m), 32'd1);
        step;
    endtask

    task test_abort;
        logic [15:0] stream;
        int          dones;
        stream = '0; dones = 0;
        din_m = 16'hFFFF; rdy_m = 1'b1; st_m = 1'b1;
        step;
        st_m = 1'b0;
        repeat (5) step;
        #2;
        R = 1'b0;
        #1;
        chk("abort_valid", 32'(vld_m), 32'd0);
        chk("abort_busy", 32'(busy_m), 32'd0);
        R = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            if (done_m || vld_m) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        din_m = 16'h5A5A; st_m = 1'b1;
        step;
        st_m = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stream = {stream[14:0], out_m};
            step;
        end
        chk("abort_fresh_stream", 32'(stream), 32'h00005A5A);
        chk("abort_fresh_done", 32'(done_m), 32'd1);
        step;
    endtask

    task test_width1;
        din_w = 1'b1; rdy_w = 1'b1; st_w = 1'b1;
        step;
        st_w = 1'b0;
        chk("w1_beat", 32'({vld_w, busy_w, out_w}), 32'b111);
        step;
        chk("w1_done", 32'({done_w, vld_w, busy_w}), 32'b100);
        st_w = 1'b1;
        step;
        st_w = 1'b0;
        chk("w1_start_dropped", 32'({done_w, vld_w, busy_w}), 32'b000);
        step;
        chk("w1_still_idle", 32'({done_w, vld_w, busy_w}), 32'b000);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        clk_run = 1'b1; R = 1'b0;
        st_m = 1'b0; rdy_m = 1'b0; din_m = '0;
        st_l = 1'b0; rdy_l = 1'b0; din_l = '0;
        st_w = 1'b0; rdy_w = 1'b0; din_w = '0;
        test_reset;
        test_basic_msb;
        test_backpressure;
        test_lsb_data_change;
        test_ignored_start;
        test_abort;
        test_width1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dffes_scan_readback.md
Name: dffes_scan_readback

Overview:
- Readback serializer for the techlib flop array. Captures a parallel snapshot of WIDTH flop Q outputs (dffes/dffr cells) on request, then shifts it out one bit per accepted beat over a valid/ready serial link.
- Sits between the fabric register columns and the configuration/debug readback port. Gives the verification and debug flow the read side of the register state that the enable-gated flops write.

Parameters:
- WIDTH, 16: number of captured flop bits; legal range 1..256.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  Single clock; all state updates on posedge.
- R  input  1  Reset; asynchronous, active-low. R=0 forces reset state immediately, independent of clk.
- start  input  1  Capture request; sampled on posedge, acted on only in IDLE.
- data_in  input  WIDTH  Parallel flop Q values; sampled only on the capture edge.
- serial_out  output  1  Current readback bit; valid while serial_valid=1.
- serial_valid  output  1  Beat offered.
- serial_ready  input  1  Consumer accepts the beat when high on the same posedge as serial_valid.
- busy  output  1  High from the capture edge until the done cycle.
- done  output  1  One-cycle pulse after the last bit is accepted.

Behaviour:
- All outputs are registered.
- Reset (R=0, asynchronous) clears the following immediately, with no wait for a clock edge:
  - state = IDLE;
  - shift register = 0; bit counter = 0;
  - serial_out = 0; serial_valid = 0; busy = 0; done = 0.
- Release of R is synchronised by the integrator. The block samples no input on the first edge after release beyond normal IDLE behaviour.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - At a posedge with start=1: shift register <= data_in; counter <= WIDTH-1; busy <= 1; serial_valid <= 1; serial_out <= first bit (per MSB_FIRST); next state SHIFT.
  - At a posedge with start=0: remain in IDLE; outputs unchanged.
- SHIFT:
  - At a posedge with serial_valid & serial_ready:
    - if counter == 0: serial_valid <= 0; done <= 1; busy <= 0; state -> DONE;
    - else: shift register advances by one bit toward the output end; serial_out <= next bit; counter decrements.
  - At a posedge with serial_ready=0: serial_out, serial_valid and counter hold, for any number of stall cycles.
- DONE: done is high for exactly one cycle, then done <= 0 and state -> IDLE.
- start is ignored in SHIFT and in DONE. A start asserted in the DONE cycle is dropped; it must be re-asserted in IDLE.
- data_in changes after the capture edge have no effect on the stream.
- Latency:
  - start edge N gives serial_valid=1 and the first bit from cycle N+1.
  - With ready held high, the last bit is accepted at edge N+WIDTH, done=1 in cycle N+WIDTH+1, and IDLE in cycle N+WIDTH+2.
  - Back-to-back capture is therefore possible every WIDTH+2 cycles.
- WIDTH=1: one beat; the counter starts at 0 and the first acceptance goes directly to DONE.
- Shift-in fill bit is 0; bits beyond the last are never presented while valid.
- Reset asserted mid-SHIFT or in DONE:
  - aborts the transfer immediately;
  - done is not pulsed for the aborted transfer;
  - serial_valid drops asynchronously.
- serial_ready while serial_valid=0 has no effect.
- The counter width is clog2(WIDTH), with a minimum of 1. The counter never wraps: decrement happens only when counter > 0.

Test Plan:
- Reset: drive R=0 mid-cycle with clk stopped -> serial_valid, busy, done and serial_out go to 0 without any clock edge.
- Basic MSB-first: WIDTH=16, data_in=16'hA5C3, start for 1 cycle, ready held 1 -> serial_out sequence over 16 cycles is 1010 0101 1100 0011; done pulses once in cycle start+17; busy is low in that same cycle.
- Backpressure: same word, serial_ready toggled 1,0,0,1 repeatedly -> serial_out and serial_valid hold through every ready=0 cycle; bitstream is identical to the basic case; done follows the 16th acceptance.
- LSB-first plus data_in change: MSB_FIRST=0, data_in=16'h0001 captured, then data_in=16'hFFFF one cycle later -> stream is 1 followed by fifteen 0s.
- Ignored starts and abort:
  - start held high throughout a transfer -> exactly one transfer occurs before DONE; a new transfer begins from IDLE only if start is still high there.
  - R pulsed low after 5 accepted bits -> no done pulse; a following start captures fresh data and streams all 16 bits.
- WIDTH=1 corner: data_in=1'b1, start -> a single beat with serial_out=1, done in cycle start+2; a second start in the DONE cycle is ignored.
